// File: rtl/mem_ctrl.sv
// ============================================================================
// Module   : mem_ctrl
// Brief    : Byte-serial RAM controller serving icache fetches and LSU loads/stores
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_ctrl #(
  parameter logic [31:0] IO_ADDR = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        inst_read_in,
  input  logic [31:0] inst_address_in,
  output logic        inst_busy_out,
  output logic        inst_enable_out,
  output logic [31:0] inst_data_out,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] mem_address_in,
  input  logic [2:0]  mem_len_in,
  input  logic [31:0] mem_data_in,
  output logic        mem_busy_out,
  output logic        mem_enable_out,
  output logic [31:0] mem_data_out,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INST_READ  = 3'd1,
    S_DATA_READ  = 3'd2,
    S_DATA_WRITE = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        busy_q, busy_d;
  logic        inst_en_q, inst_en_d;
  logic        mem_en_q, mem_en_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_wr_q, ram_wr_d;

  logic [2:0]  w_mem_len;
  logic        w_io_stall;
  logic [1:0]  w_cap_idx;
  logic [1:0]  w_next_idx;
  logic        w_more;
  logic [31:0] w_next_addr;

  always_comb begin
    case (mem_len_in)
      3'd1:    w_mem_len = 3'd1;
      3'd2:    w_mem_len = 3'd2;
      default: w_mem_len = 3'd4;
    endcase
  end

  assign w_io_stall  = (mem_address_in >= IO_ADDR) && io_buffer_full;
  // cnt counts cycles spent in a read state; byte cnt-1 is on ram_din now
  assign w_cap_idx   = cnt_q[1:0] - 2'd1;
  assign w_next_idx  = cnt_q[1:0] + 2'd1;
  assign w_more      = ({1'b0, cnt_q} + 4'd1) < {1'b0, len_q};
  assign w_next_addr = addr_q + {29'd0, cnt_q} + 32'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    inst_data_d = inst_data_q;
    mem_data_d  = mem_data_q;
    ram_a_d     = ram_a_q;
    inst_en_d   = 1'b0;
    mem_en_d    = 1'b0;
    ram_dout_d  = 8'd0;
    ram_wr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_write_in) begin
          if (!w_io_stall) begin
            state_d    = S_DATA_WRITE;
            addr_d     = mem_address_in;
            len_d      = w_mem_len;
            wdata_d    = mem_data_in;
            cnt_d      = 3'd0;
            ram_a_d    = mem_address_in;
            ram_dout_d = mem_data_in[7:0];
            ram_wr_d   = 1'b1;
          end
        end else if (mem_read_in) begin
          state_d = S_DATA_READ;
          addr_d  = mem_address_in;
          len_d   = w_mem_len;
          cnt_d   = 3'd0;
          buf_d   = 32'd0;
          ram_a_d = mem_address_in;
        end else if (inst_read_in) begin
          state_d = S_INST_READ;
          addr_d  = inst_address_in;
          len_d   = 3'd4;
          cnt_d   = 3'd0;
          buf_d   = 32'd0;
          ram_a_d = inst_address_in;
        end
      end

      S_INST_READ, S_DATA_READ: begin
        if (cnt_q != 3'd0) begin
          buf_d[{w_cap_idx, 3'b000} +: 8] = ram_din;
        end
        if (w_more) begin
          ram_a_d = w_next_addr;
        end
        if (cnt_q == len_q) begin
          state_d = S_DONE;
          if (state_q == S_INST_READ) begin
            inst_en_d   = 1'b1;
            inst_data_d = buf_d;
          end else begin
            mem_en_d   = 1'b1;
            mem_data_d = buf_d;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_DATA_WRITE: begin
        if (w_more) begin
          ram_a_d    = w_next_addr;
          ram_dout_d = wdata_q[{w_next_idx, 3'b000} +: 8];
          ram_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end else begin
          state_d  = S_DONE;
          mem_en_d = 1'b1;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      busy_q      <= 1'b0;
      inst_en_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      inst_data_q <= 32'd0;
      mem_data_q  <= 32'd0;
      ram_a_q     <= 32'd0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      busy_q      <= busy_d;
      inst_en_q   <= inst_en_d;
      mem_en_q    <= mem_en_d;
      inst_data_q <= inst_data_d;
      mem_data_q  <= mem_data_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
    end
  end

  assign inst_busy_out   = busy_q;
  assign mem_busy_out    = busy_q;
  assign inst_enable_out = inst_en_q;
  assign mem_enable_out  = mem_en_q;
  assign inst_data_out   = inst_data_q;
  assign mem_data_out    = mem_data_q;
  assign ram_a           = ram_a_q;
  assign ram_dout        = ram_dout_q;
  assign ram_wr          = ram_wr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Directed self-checking bench for mem_ctrl with a byte RAM model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        inst_read_in;
  logic [31:0] inst_address_in;
  logic        inst_busy_out;
  logic        inst_enable_out;
  logic [31:0] inst_data_out;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [31:0] mem_address_in;
  logic [2:0]  mem_len_in;
  logic [31:0] mem_data_in;
  logic        mem_busy_out;
  logic        mem_enable_out;
  logic [31:0] mem_data_out;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_buffer_full;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:4095];

  mem_ctrl dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .inst_read_in    (inst_read_in),
    .inst_address_in (inst_address_in),
    .inst_busy_out   (inst_busy_out),
    .inst_enable_out (inst_enable_out),
    .inst_data_out   (inst_data_out),
    .mem_read_in     (mem_read_in),
    .mem_write_in    (mem_write_in),
    .mem_address_in  (mem_address_in),
    .mem_len_in      (mem_len_in),
    .mem_data_in     (mem_data_in),
    .mem_busy_out    (mem_busy_out),
    .mem_enable_out  (mem_enable_out),
    .mem_data_out    (mem_data_out),
    .ram_din         (ram_din),
    .ram_dout        (ram_dout),
    .ram_a           (ram_a),
    .ram_wr          (ram_wr),
    .io_buffer_full  (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // RAM returns the byte addressed in the previous cycle
  always @(posedge clk_in) begin
    if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
    ram_din <= ram[ram_a[11:0]];
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_mem_en(output int cyc, output logic [31:0] d);
    cyc = -1;
    d   = 32'hxxxx_xxxx;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (mem_enable_out) begin
        cyc = c;
        d   = mem_data_out;
        break;
      end
    end
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick();
    tick();
    if ({inst_busy_out, mem_busy_out, inst_enable_out, mem_enable_out, ram_wr} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000",
        {inst_busy_out, mem_busy_out, inst_enable_out, mem_enable_out, ram_wr});
    end
    checks++;
    rst_in = 1'b0;
    tick();
    if ({inst_data_out, mem_data_out} !== 64'd0) begin
      errors++; $display("FAIL reset_data got %h %h want 0 0", inst_data_out, mem_data_out);
    end
    checks++;
    if (ram_a !== 32'd0 || ram_dout !== 8'd0) begin
      errors++; $display("FAIL reset_ram got a=%h d=%h want 0 0", ram_a, ram_dout);
    end
    checks++;
  endtask

  task automatic test_fetch();
    inst_address_in = 32'h100;
    inst_read_in    = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      inst_read_in = 1'b0;
      if (inst_busy_out !== (c <= 6)) begin
        errors++; $display("FAIL fetch_busy c=%0d got %b want %b", c, inst_busy_out, c <= 6);
      end
      checks++;
      if (inst_enable_out !== (c == 6) || mem_enable_out !== 1'b0) begin
        errors++; $display("FAIL fetch_enable c=%0d got i=%b m=%b want i=%b m=0",
          c, inst_enable_out, mem_enable_out, c == 6);
      end
      checks++;
      if (c <= 4 && ram_a !== 32'h100 + 32'(c - 1)) begin
        errors++; $display("FAIL fetch_addr c=%0d got %h want %h", c, ram_a, 32'h100 + 32'(c - 1));
      end
      if (c <= 4) checks++;
      if (c == 6 && inst_data_out !== 32'h9300_0013) begin
        errors++; $display("FAIL fetch_data got %h want 93000013", inst_data_out);
      end
      if (c == 6) checks++;
    end
  endtask

  task automatic test_load();
    int cyc;
    logic [31:0] d;
    mem_address_in = 32'h203; mem_len_in = 3'd1; mem_read_in = 1'b1;
    wait_mem_en(cyc, d);
    if (cyc != 3 || d !== 32'h0000_00F0) begin
      errors++; $display("FAIL load_b got cyc=%0d d=%h want cyc=3 d=000000f0", cyc, d);
    end
    checks++;
    mem_address_in = 32'h200; mem_len_in = 3'd2; mem_read_in = 1'b1;
    wait_mem_en(cyc, d);
    if (cyc != 4 || d !== 32'h0000_1234) begin
      errors++; $display("FAIL load_h got cyc=%0d d=%h want cyc=4 d=00001234", cyc, d);
    end
    checks++;
  endtask

  task automatic test_store();
    int cyc;
    logic [31:0] d;
    logic [7:0] exp_b [4];
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    mem_address_in = 32'h400; mem_len_in = 3'd4; mem_data_in = 32'hDEAD_BEEF; mem_write_in = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 4) begin
        if (ram_wr !== 1'b1 || ram_a !== 32'h400 + 32'(c - 1) || ram_dout !== exp_b[c-1]) begin
          errors++; $display("FAIL store_byte c=%0d got wr=%b a=%h d=%h want 1 %h %h",
            c, ram_wr, ram_a, ram_dout, 32'h400 + 32'(c - 1), exp_b[c-1]);
        end
      end else begin
        if (ram_wr !== 1'b0 || ram_dout !== 8'd0 || mem_enable_out !== 1'b1) begin
          errors++; $display("FAIL store_done got wr=%b d=%h en=%b want 0 00 1",
            ram_wr, ram_dout, mem_enable_out);
        end
      end
      checks++;
      if (c < 5 && mem_enable_out !== 1'b0) begin
        errors++; $display("FAIL store_early_en c=%0d got 1 want 0", c);
      end
      if (c < 5) checks++;
    end
    mem_write_in = 1'b0;
    tick();
    // len 0 is an out-of-range size and must behave as a word access
    mem_address_in = 32'h400; mem_len_in = 3'd0; mem_read_in = 1'b1;
    wait_mem_en(cyc, d);
    if (cyc != 6 || d !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL store_readback got cyc=%0d d=%h want cyc=6 d=deadbeef", cyc, d);
    end
    checks++;
  endtask

  task automatic test_priority();
    inst_address_in = 32'h0;  inst_read_in = 1'b1;
    mem_address_in  = 32'h80; mem_len_in = 3'd4; mem_read_in = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (mem_enable_out !== (c == 6) || inst_enable_out !== (c == 13)) begin
        errors++; $display("FAIL prio_enable c=%0d got m=%b i=%b want m=%b i=%b",
          c, mem_enable_out, inst_enable_out, c == 6, c == 13);
      end
      checks++;
      if (c == 6 && mem_data_out !== 32'h4433_2211) begin
        errors++; $display("FAIL prio_mem_data got %h want 44332211", mem_data_out);
      end
      if (c == 6) checks++;
      if (c == 13 && inst_data_out !== 32'h0403_0201) begin
        errors++; $display("FAIL prio_inst_data got %h want 04030201", inst_data_out);
      end
      if (c == 13) checks++;
      if (c == 7 && inst_busy_out !== 1'b0) begin
        errors++; $display("FAIL prio_idle got busy=%b want 0", inst_busy_out);
      end
      if (c == 7) checks++;
      if (c == 1) inst_read_in = 1'b0;
      if (c == 6) mem_read_in = 1'b0;
      if (c == 7) inst_read_in = 1'b1;
      if (c == 8) inst_read_in = 1'b0;
    end
  endtask

  task automatic test_io_stall();
    mem_address_in = 32'h0003_0000; mem_len_in = 3'd1; mem_data_in = 32'h0000_005A;
    mem_write_in = 1'b1; io_buffer_full = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (ram_wr !== 1'b0 || mem_busy_out !== 1'b0) begin
        errors++; $display("FAIL io_stall c=%0d got wr=%b busy=%b want 0 0", c, ram_wr, mem_busy_out);
      end
      checks++;
    end
    io_buffer_full = 1'b0;
    tick();
    if (ram_wr !== 1'b1 || ram_a !== 32'h0003_0000 || ram_dout !== 8'h5A) begin
      errors++; $display("FAIL io_write got wr=%b a=%h d=%h want 1 00030000 5a", ram_wr, ram_a, ram_dout);
    end
    checks++;
    tick();
    if (mem_enable_out !== 1'b1) begin
      errors++; $display("FAIL io_enable got %b want 1", mem_enable_out);
    end
    checks++;
    mem_write_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    int seen;
    inst_address_in = 32'h100; inst_read_in = 1'b1;
    tick();
    inst_read_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    if ({inst_busy_out, inst_enable_out, mem_enable_out, ram_wr} !== 4'b0 ||
        ram_a !== 32'd0 || inst_data_out !== 32'd0) begin
      errors++; $display("FAIL abort_outputs got busy=%b ien=%b men=%b wr=%b a=%h d=%h want all 0",
        inst_busy_out, inst_enable_out, mem_enable_out, ram_wr, ram_a, inst_data_out);
    end
    checks++;
    seen = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (inst_enable_out || inst_busy_out) seen++;
    end
    if (seen != 0) begin
      errors++; $display("FAIL abort_quiet got %0d active cycles want 0", seen);
    end
    checks++;
    inst_read_in = 1'b1;
    seen = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      inst_read_in = 1'b0;
      if (inst_enable_out) begin
        seen = c;
        break;
      end
    end
    if (seen != 6 || inst_data_out !== 32'h9300_0013) begin
      errors++; $display("FAIL abort_refetch got cyc=%0d d=%h want cyc=6 d=93000013", seen, inst_data_out);
    end
    checks++;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h00; ram[12'h102] = 8'h00; ram[12'h103] = 8'h93;
    ram[12'h200] = 8'h34; ram[12'h201] = 8'h12; ram[12'h203] = 8'hF0;
    ram[12'h080] = 8'h11; ram[12'h081] = 8'h22; ram[12'h082] = 8'h33; ram[12'h083] = 8'h44;
    ram[12'h000] = 8'h01; ram[12'h001] = 8'h02; ram[12'h002] = 8'h03; ram[12'h003] = 8'h04;
    rst_in = 1'b1;
    inst_read_in = 1'b0; inst_address_in = 32'd0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; mem_address_in = 32'd0;
    mem_len_in = 3'd0; mem_data_in = 32'd0; io_buffer_full = 1'b0;

    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_priority();
    test_io_stall();
    test_reset_abort();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the instruction cache / load-store unit and the 8-bit RAM bus. It accepts one 32-bit instruction-fetch request or one 1/2/4-byte data request at a time. It sequences the byte accesses on the RAM port and returns the assembled word with a one-cycle enable pulse. Data requests have priority over instruction fetches.

## Interface
- IO_ADDR, 32'h0003_0000, base of the memory-mapped IO region; any address >= IO_ADDR is IO.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset; synchronous, active-high.
- inst_read_in  input  1  instruction fetch request from the icache.
- inst_address_in  input  32  fetch address.
- inst_busy_out  output  1  controller not idle; the icache must not raise a new request.
- inst_enable_out  output  1  one-cycle pulse; inst_data_out is valid.
- inst_data_out  output  32  fetched word, little-endian.
- mem_read_in  input  1  data load request from the LSU, held until mem_enable_out.
- mem_write_in  input  1  data store request from the LSU, held until mem_enable_out.
- mem_address_in  input  32  data address.
- mem_len_in  input  3  access size in bytes: 1, 2 or 4. Any other value is treated as 4.
- mem_data_in  input  32  store data; byte i is mem_data_in[8i+7:8i].
- mem_busy_out  output  1  controller not idle.
- mem_enable_out  output  1  one-cycle pulse; the load or store has completed.
- mem_data_out  output  32  load data, zero-extended. The LSU sign-extends.
- ram_din  input  8  RAM read byte. It holds the byte addressed by ram_a in the previous cycle.
- ram_dout  output  8  RAM write byte.
- ram_a  output  32  RAM byte address.
- ram_wr  output  1  1 = write, 0 = read.
- io_buffer_full  input  1  IO output buffer full.

## Operation
- States: IDLE, INST_READ, DATA_READ, DATA_WRITE, DONE. There is a byte counter cnt[2:0] and a latched address, length and data.
- IDLE, checked in this order:
  - mem_write_in: accept, except when the address is in the IO region and io_buffer_full=1. In that case nothing is accepted this cycle and the instruction fetch is not served either.
  - mem_read_in: accept.
  - inst_read_in: accept, with length 4.
- On accept:
  - Latch the address, length and store data; set cnt=0.
  - The requester's signals are ignored for the rest of the transaction. The icache drops inst_read_in while busy, so the address must be latched.
- DATA_READ and INST_READ:
  - Drive ram_a = addr+i for i=0..N-1 in consecutive cycles.
  - Capture ram_din into byte i one cycle after the corresponding ram_a.
  - After byte N-1 is captured, go to DONE.
- DATA_WRITE:
  - Drive ram_a = addr+i, ram_dout = byte i and ram_wr=1 for i=0..N-1.
  - Then go to DONE.
- DONE:
  - Pulse the enable of the served side: inst_enable_out or mem_enable_out, never both.
  - Data outputs hold the result. Bytes beyond N read as zero.
  - Next state is IDLE. Requests still asserted in DONE are ignored.
- inst_busy_out = mem_busy_out = (state != IDLE).
- Address arithmetic is 32-bit and wraps modulo 2^32.
- When not writing: ram_wr=0 and ram_dout=0. ram_a holds its last value when idle.

## Timing
- Reset: state IDLE, cnt 0. All outputs are 0: enables, busies, data, ram_a, ram_dout, ram_wr.
- Reset in any state aborts the transaction. No enable pulse is produced, and ram_wr is 0 in the next cycle.
- Read of N bytes accepted in cycle T:
  - ram_a = addr+i in cycle T+1+i.
  - Byte i sampled at the end of cycle T+2+i.
  - Enable high in cycle T+N+2.
  - IDLE in T+N+3.
- Instruction fetch: enable in T+6.
- Write of N bytes accepted in T:
  - ram_wr=1 in cycles T+1..T+N.
  - Enable in T+N+1.
- Minimum gap between two accepts is N+3 cycles for reads and N+2 for writes.
- Simultaneous data and instruction requests in IDLE: data is served first. The fetch is accepted at the first IDLE cycle in which no data request is eligible.

## Test plan
- Reset, then inst_read_in=1 at addr 0x100 with RAM bytes 13,00,00,93 at 0x100..0x103:
  - inst_enable_out high exactly in T+6 with inst_data_out=0x93000013.
  - inst_busy_out high T+1..T+6.
- Load, len 1 at 0x203 (byte 0xF0) -> mem_data_out=0x000000F0 at T+3. Load, len 2 at 0x200 (bytes 34,12) -> 0x00001234 at T+4.
- Store 0xDEADBEEF, len 4 at 0x400 -> ram_wr=1 in T+1..T+4 with (a,d) = (400,EF), (401,BE), (402,AD), (403,DE); mem_enable_out in T+5; a following read returns 0xDEADBEEF.
- Simultaneous inst_read_in (0x0) and mem_read_in (0x80, len 4) in IDLE -> data served first, with mem_enable_out at T+6. The fetch (icache re-asserts once IDLE) completes with inst_enable_out 6 cycles after acceptance at T+7, i.e. at T+13.
- Store len 1 to 0x30000 with io_buffer_full=1 for 5 cycles -> no ram_wr and busy stays low. Once io_buffer_full=0, ram_wr=1 in the next cycle with ram_a=0x30000.
- rst_in=1 during cycle T+3 of a fetch -> no inst_enable_out and outputs 0 next cycle. A new fetch after reset completes normally.
